// File: rtl/pic_reg_resp.sv
// PIC responder: memory-mapped registers, per-source gateways and a
// registered highest-priority claim toward the core.
//
// Ports:
//   clk, rst_l          clock, async active-low reset
//   picm_rden/mken/wren read, mask and write requests from the LSU
//   picm_addr/wr_data   shared address and write data
//   picm_rd_data        read data or write mask, one cycle after request
//   extintsrc_req       raw async interrupt sources (bit 0 unused)
//   mexintpend          registered: an eligible source is pending
//   claimid, claimpl    registered id and priority of the winner
//   scan_mode           no functional effect
module pic_reg_resp #(
    parameter int          TOTAL_INT     = 8,
    parameter logic [31:0] PIC_BASE_ADDR = 32'hF00C0000,
    parameter int          PIC_BITS      = 15,
    parameter int          PRI_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 picm_rden,
    input  logic                 picm_mken,
    input  logic                 picm_wren,
    input  logic [31:0]          picm_addr,
    input  logic [31:0]          picm_wr_data,
    output logic [31:0]          picm_rd_data,
    input  logic [TOTAL_INT-1:0] extintsrc_req,
    output logic                 mexintpend,
    output logic [7:0]           claimid,
    output logic [PRI_W-1:0]     claimpl,
    input  logic                 scan_mode
);
    localparam int IW = $clog2(TOTAL_INT);

    logic [PRI_W-1:0]     meipl_q [TOTAL_INT];
    logic [PRI_W-1:0]     meipl_d [TOTAL_INT];
    logic [1:0]           gwctrl_q [TOTAL_INT];
    logic [1:0]           gwctrl_d [TOTAL_INT];
    logic [TOTAL_INT-1:0] meie_q, meie_d;
    logic                 mpiccfg_q, mpiccfg_d;
    logic [PRI_W-1:0]     meipt_q, meipt_d;
    logic [TOTAL_INT-1:0] sync1_q, sync2_q, lvl_q, edge_q, edge_d;
    logic [TOTAL_INT-1:0] lvl, meip, gwclr;
    logic [31:0]          rd_data_q, rd_data_d;
    logic [7:0]           claimid_q, claimid_d;
    logic [PRI_W-1:0]     claimpl_q, claimpl_d;
    logic                 mexintpend_q, mexintpend_d;

    logic                 hit, src_ok, reg0, wr_ok;
    int                   grp;
    logic [9:0]           idx;
    logic [IW-1:0]        s;
    logic [31:0]          rd_val, mask_val;

    logic                 unused_ok;
    assign unused_ok = ^{scan_mode, picm_addr[1:0], picm_wr_data[31:PRI_W]};

    // Address decode, read value and writable mask
    always_comb begin
        hit      = picm_addr[31:PIC_BITS] == PIC_BASE_ADDR[31:PIC_BITS];
        grp      = int'(picm_addr[PIC_BITS-1:12]);
        idx      = picm_addr[11:2];
        src_ok   = hit && (idx != '0) && (int'(idx) < TOTAL_INT);
        reg0     = hit && (idx == '0);
        s        = idx[IW-1:0];
        rd_val   = '0;
        mask_val = '0;
        case (grp)
            0: if (src_ok) begin
                rd_val[PRI_W-1:0]   = meipl_q[s];
                mask_val[PRI_W-1:0] = '1;
            end
            1: if (reg0) rd_val[TOTAL_INT-1:0] = meip;
            2: if (src_ok) begin
                rd_val[0]   = meie_q[s];
                mask_val[0] = 1'b1;
            end
            3: if (reg0) begin
                rd_val[0]   = mpiccfg_q;
                mask_val[0] = 1'b1;
            end
            4: if (src_ok) begin
                rd_val[1:0]   = gwctrl_q[s];
                mask_val[1:0] = 2'b11;
            end
            6: if (reg0) begin
                rd_val[PRI_W-1:0]   = meipt_q;
                mask_val[PRI_W-1:0] = '1;
            end
            default: ;
        endcase
    end

    // Register writes; a write sharing the cycle with a read is dropped
    always_comb begin
        wr_ok     = picm_wren & ~picm_rden & ~picm_mken;
        meie_d    = meie_q;
        mpiccfg_d = mpiccfg_q;
        meipt_d   = meipt_q;
        gwclr     = '0;
        for (int i = 0; i < TOTAL_INT; i++) begin
            meipl_d[i]  = meipl_q[i];
            gwctrl_d[i] = gwctrl_q[i];
        end
        if (wr_ok && src_ok) begin
            case (grp)
                0: meipl_d[s]  = picm_wr_data[PRI_W-1:0];
                2: meie_d[s]   = picm_wr_data[0];
                4: gwctrl_d[s] = picm_wr_data[1:0];
                5: gwclr[s]    = 1'b1;
                default: ;
            endcase
        end
        if (wr_ok && reg0) begin
            case (grp)
                3: mpiccfg_d = picm_wr_data[0];
                6: meipt_d   = picm_wr_data[PRI_W-1:0];
                default: ;
            endcase
        end
        rd_data_d = rd_data_q;
        if (picm_rden)
            rd_data_d = rd_val;
        else if (picm_mken)
            rd_data_d = mask_val;
    end

    // Gateways: edge latch set beats a same-cycle clear
    always_comb begin
        for (int i = 0; i < TOTAL_INT; i++) begin
            lvl[i]    = sync2_q[i] ^ gwctrl_q[i][0];
            edge_d[i] = gwctrl_q[i][1] &
                        ((lvl[i] & ~lvl_q[i]) | (edge_q[i] & ~gwclr[i]));
            meip[i]   = (i != 0) &&
                        (gwctrl_q[i][1] ? edge_q[i] : lvl[i]);
        end
    end

    // Arbiter: strict compare keeps the lowest id on ties
    always_comb begin
        claimid_d    = '0;
        claimpl_d    = '0;
        mexintpend_d = 1'b0;
        for (int i = 1; i < TOTAL_INT; i++) begin
            if (meie_q[i] && meip[i] &&
                (mpiccfg_q ? (meipl_q[i] != '0 && meipl_q[i] < meipt_q)
                           : (meipl_q[i] > meipt_q))) begin
                if (!mexintpend_d ||
                    (mpiccfg_q ? (meipl_q[i] < claimpl_d)
                               : (meipl_q[i] > claimpl_d))) begin
                    mexintpend_d = 1'b1;
                    claimpl_d    = meipl_q[i];
                    claimid_d    = 8'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < TOTAL_INT; i++) begin
                meipl_q[i]  <= '0;
                gwctrl_q[i] <= '0;
            end
            meie_q       <= '0;
            mpiccfg_q    <= 1'b0;
            meipt_q      <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            lvl_q        <= '0;
            edge_q       <= '0;
            rd_data_q    <= '0;
            claimid_q    <= '0;
            claimpl_q    <= '0;
            mexintpend_q <= 1'b0;
        end else begin
            for (int i = 0; i < TOTAL_INT; i++) begin
                meipl_q[i]  <= meipl_d[i];
                gwctrl_q[i] <= gwctrl_d[i];
            end
            meie_q       <= meie_d;
            mpiccfg_q    <= mpiccfg_d;
            meipt_q      <= meipt_d;
            sync1_q      <= extintsrc_req;
            sync2_q      <= sync1_q;
            lvl_q        <= lvl;
            edge_q       <= edge_d;
            rd_data_q    <= rd_data_d;
            claimid_q    <= claimid_d;
            claimpl_q    <= claimpl_d;
            mexintpend_q <= mexintpend_d;
        end
    end

    assign picm_rd_data = rd_data_q;
    assign claimid      = claimid_q;
    assign claimpl      = claimpl_q;
    assign mexintpend   = mexintpend_q;

endmodule
